pixel_gap_filling: RTL

- Parametrised successor to the fixed-geometry X-direction edge filler.
- Scans a frame buffer in single-port 32-bit RAM and fills single-pixel gaps between two marked neighbours, in either X (horizontal) or Y (vertical) mode.
- Image geometry, skipped border lines, memory read latency and the mark/fill values are all parameters.
- Sits in the post-processing chain next to the other enable/done image passes, sharing the frame RAM via the arbiter's pause signal.

---
 rtl/pixel_gap_filling_if.sv | 13 +
 rtl/pixel_gap_filling.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_gap_filling_if.sv
// rtl/pixel_gap_filling_if.sv - frame RAM port bundle between the gap filler and the shared frame buffer
interface pixel_gap_filling_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_read;
  logic              wren;
  logic [DATA_W-1:0] data_write;
  logic [ADDR_W-1:0] address;

  modport master (input data_read, output wren, output data_write, output address);
  modport slave  (output data_read, input wren, input data_write, input address);
endinterface

// File: rtl/pixel_gap_filling.sv
// rtl/pixel_gap_filling.sv - single-pixel gap filler over frame RAM, X or Y mode; PIXEL_GAP_FILL_COUNT_EN adds fill_count
module pixel_gap_filling #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int SKIP_LINES = 7,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int MARK_VALUE = 1,
  parameter int FILL_VALUE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pause,
  input  logic                enable,
  input  logic                direction,
  pixel_gap_filling_if.master ram,
`ifdef PIXEL_GAP_FILL_COUNT_EN
  output logic [ADDR_W-1:0]   fill_count,
`endif
  output logic                done
);

  typedef enum logic [2:0] {S_IDLE, S_RD_C, S_RD_R, S_RD_L, S_WRITE, S_NEXT, S_DONE} state_t;

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ADDR_W-1:0] START_P = ADDR_W'(SKIP_LINES * IMG_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_P  = ADDR_W'((IMG_HEIGHT - SKIP_LINES) * IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] WIDTH_P = ADDR_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0]  LAT_END = CNT_W'(RD_LAT - 1);
  localparam logic [COL_W-1:0]  COL_END = COL_W'(IMG_WIDTH - 1);
  localparam logic [DATA_W-1:0] MARK    = DATA_W'(MARK_VALUE);
  localparam logic [DATA_W-1:0] FILL    = DATA_W'(FILL_VALUE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] step;
  logic [COL_W-1:0]  col_inc;
  logic              next_edge;
  logic              gap;

  // Neighbour step, column tracking for the following pixel, and the gap test on the left read
  always_comb begin
    step      = dir_q ? WIDTH_P : ADDR_W'(1);
    col_inc   = (col_q == COL_END) ? '0 : col_q + 1'b1;
    next_edge = (col_inc == '0) || (col_inc == COL_END);
    gap       = (c_q != MARK) && (ram.data_read == MARK) && (r_q == MARK);
  end

  // Next-state and registered-output values; pause freezes everything but drops wren
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    col_d   = col_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    r_d     = r_q;
    wren_d  = 1'b0;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    done_d  = done_q;
    if (pause) begin
      // the read in progress is retimed from scratch once the arbiter releases the RAM
      if (state_q == S_RD_C || state_q == S_RD_R || state_q == S_RD_L) cnt_d = '0;
    end else if (state_q != S_IDLE && !enable) begin
      state_d = S_IDLE;
      wdata_d = '0;
      addr_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && !done_q) begin
            dir_d   = direction;
            p_d     = START_P;
            col_d   = '0;
            cnt_d   = '0;
            // the first pixel sits in column 0, which X mode never touches
            state_d = direction ? S_RD_C : S_NEXT;
          end
        end
        S_RD_C: begin
          if (cnt_q == LAT_END) begin
            c_d     = ram.data_read;
            cnt_d   = '0;
            state_d = S_RD_R;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RD_R: begin
          if (cnt_q == LAT_END) begin
            r_d     = ram.data_read;
            cnt_d   = '0;
            state_d = S_RD_L;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RD_L: begin
          if (cnt_q == LAT_END) begin
            cnt_d   = '0;
            wren_d  = 1'b1;
            wdata_d = gap ? FILL : c_q;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          // wren low here means a pause swallowed the pulse, so issue it again
          if (wren_q) state_d = S_NEXT;
          else        wren_d  = 1'b1;
        end
        S_NEXT: begin
          if (p_q == LAST_P) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            p_d     = p_q + 1'b1;
            col_d   = col_inc;
            state_d = (!dir_q && next_edge) ? S_NEXT : S_RD_C;
          end
        end
        S_DONE:  ;
        default: state_d = S_IDLE;
      endcase
      case (state_d)
        S_RD_C, S_WRITE: addr_d = p_d;
        S_RD_R:          addr_d = p_d + step;
        S_RD_L:          addr_d = p_d - step;
        default:         ;
      endcase
    end
  end

  // State, pointer, captured words and registered RAM outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      col_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      c_q     <= '0;
      r_q     <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      r_q     <= r_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

`ifdef PIXEL_GAP_FILL_COUNT_EN
  logic [ADDR_W-1:0] fill_count_q;

  // Count fills when the write is decided, so a reissued write is not counted twice
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_count_q <= '0;
    end else if (!pause && state_q == S_IDLE) begin
      fill_count_q <= '0;
    end else if (!pause && enable && state_q == S_RD_L && cnt_q == LAT_END && gap) begin
      fill_count_q <= fill_count_q + 1'b1;
    end
  end

  assign fill_count = fill_count_q;
`endif

  assign ram.wren       = wren_q;
  assign ram.data_write = wdata_q;
  assign ram.address    = addr_q;
  assign done           = done_q;

endmodule
